// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// uart_rx_cfg : configurable UART receiver (data width, parity, stop bits, baud)
// Rev 1.0
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 13020,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int P  = (PARITY != 0) ? 1 : 0;
    localparam int N  = 1 + DATA_BITS + P + STOP_BITS;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(N);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   rx_s, rx_d;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_acc, par_bit, stop_err;
    logic                   cnt_clr, idx_clr, idx_inc, shift_en, par_en, stop_en, done;
    logic                   bit_tick, par_err, frame_err;

    assign rx_s     = sync_ff[SYNC_STAGES-1];
    assign bit_tick = (cnt == BIT_LAST);
    assign o_busy   = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_ff <= '1;
            rx_d    <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_rx};
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        done       = 1'b0;
        case (state)
            // Only a high-to-low transition starts a frame; a stuck-low line never does.
            S_IDLE: if (rx_d && !rx_s) begin
                state_next = S_START;
                cnt_clr    = 1'b1;
            end
            S_START: if (cnt == HALF_LAST) begin
                cnt_clr    = 1'b1;
                idx_clr    = 1'b1;
                state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (bit_tick) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (idx == DATA_LAST) begin
                    idx_clr    = 1'b1;
                    state_next = (P != 0) ? S_PARITY : S_STOP;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            S_PARITY: if (bit_tick) begin
                cnt_clr    = 1'b1;
                par_en     = 1'b1;
                state_next = S_STOP;
            end
            // Leaving at the last stop sample re-arms IDLE mid-stop-bit for back-to-back frames.
            S_STOP: if (bit_tick) begin
                cnt_clr = 1'b1;
                stop_en = 1'b1;
                if (idx == STOP_LAST) begin
                    idx_clr    = 1'b1;
                    done       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        par_err = 1'b0;
        if (PARITY == 1)      par_err = ~par_acc;
        else if (PARITY == 2) par_err = par_acc;
    end

    assign frame_err = stop_err | ~rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            par_bit      <= 1'b0;
            stop_err     <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;

            if (cnt_clr || state == S_IDLE) cnt <= '0;
            else                            cnt <= cnt + CW'(1);

            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + IW'(1);

            if (state == S_IDLE) begin
                par_acc  <= 1'b0;
                par_bit  <= 1'b0;
                stop_err <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                par_acc <= par_acc ^ rx_s;
            end
            if (par_en) begin
                par_bit <= rx_s;
                par_acc <= par_acc ^ rx_s;
            end
            if (stop_en) stop_err <= frame_err;

            if (done) begin
                o_data       <= shreg;
                o_data_valid <= 1'b1;
                o_parity_err <= par_err;
                o_frame_err  <= frame_err;
                o_break      <= frame_err & ~(|shreg) & ~par_bit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_cfg : directed bench for uart_rx_cfg (8N1, 7E1 and 8N2 instances)
// Rev 1.0
// ============================================================================
module tb_uart_rx_cfg;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic       rx0, rx1, rx2;
    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic [2:0] dv, perr, ferr, brk, busy;
    logic [8:0] dat [3];

    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         vq [3][$];
    logic [8:0] dq [3][$];
    logic [2:0] fq [3][$];
    int         brise [3];
    int         bfall [3];
    logic [2:0] busy_prev = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLKS_PER_BIT(C)) u0 (
        .i_clk(clk), .i_rst(rst[0]), .i_rx(rx0), .o_data(d0), .o_data_valid(dv[0]),
        .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_break(brk[0]), .o_busy(busy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2)) u1 (
        .i_clk(clk), .i_rst(rst[1]), .i_rx(rx1), .o_data(d1), .o_data_valid(dv[1]),
        .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_break(brk[1]), .o_busy(busy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u2 (
        .i_clk(clk), .i_rst(rst[2]), .i_rx(rx2), .o_data(d2), .o_data_valid(dv[2]),
        .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_break(brk[2]), .o_busy(busy[2]));

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {2'b00, d1};
    assign dat[2] = {1'b0, d2};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
                vq[i].push_back(cyc);
                dq[i].push_back(dat[i]);
                fq[i].push_back({perr[i], ferr[i], brk[i]});
            end
            if (busy[i] && !busy_prev[i]) brise[i] = cyc;
            if (!busy[i] && busy_prev[i]) bfall[i] = cyc;
        end
        busy_prev = busy;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input int u, input logic v);
        case (u)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Drives seq[0] first, each symbol held for one bit time.
    task automatic drive_line(input int u, input logic [31:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(u, seq[i]);
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int bits);
        repeat (bits * C) @(posedge clk);
        #1;
    endtask

    task automatic clear_q(input int u);
        vq[u].delete();
        dq[u].delete();
        fq[u].delete();
    endtask

    // Checks exactly one completed frame with given data and {perr,ferr,brk}.
    task automatic check_one(input string tag, input int u, input logic [8:0] data, input logic [2:0] flags);
        check_value({tag, "_count"}, vq[u].size(), 1);
        check_value({tag, "_data"}, (dq[u].size() > 0) ? dq[u][0] : 9'h1FF, data);
        check_value({tag, "_flags"}, (fq[u].size() > 0) ? fq[u][0] : 3'b111, flags);
    endtask

    initial begin
        rst = 3'b111;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_data0", d0, 8'h00);
        check_value("rst_busy", busy, 3'b000);
        check_value("rst_valid", dv, 3'b000);
        check_value("rst_flags", {perr, ferr, brk}, 9'h000);
        rst = 3'b000;
        idle(1);

        // 8N1 0xA5, latency from t0 (busy rises at t0+1)
        clear_q(0);
        drive_line(0, {1'b1, 8'hA5, 1'b0}, 10);
        idle(2);
        check_one("a5", 0, 9'h0A5, 3'b000);
        check_value("a5_latency", ((vq[0].size() > 0) ? vq[0][0] : 0) - (brise[0] - 1), 153);
        check_value("a5_busy_fall", bfall[0] - (brise[0] - 1), 153);

        // Glitch: 4 low cycles, false start sampled at t0+8
        clear_q(0);
        rx0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx0 = 1'b1;
        idle(3);
        check_value("glitch_count", vq[0].size(), 0);
        check_value("glitch_busy_len", bfall[0] - brise[0], 8);

        // 7E1 parity: 0x41 has even weight, so parity bit 1 is wrong
        clear_q(1);
        drive_line(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
        idle(1);
        check_one("par_bad", 1, 9'h041, 3'b100);
        clear_q(1);
        drive_line(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10);
        idle(1);
        check_one("par_ok", 1, 9'h041, 3'b000);

        // Framing error without break
        clear_q(0);
        drive_line(0, {1'b0, 8'h5A, 1'b0}, 10);
        rx0 = 1'b1;
        idle(2);
        check_one("ferr", 0, 9'h05A, 3'b010);

        // Break: 40 bit times low, one frame only
        clear_q(0);
        rx0 = 1'b0;
        idle(40);
        check_one("brk", 0, 9'h000, 3'b011);
        rx0 = 1'b1;
        idle(2);
        check_value("brk_after_rise", vq[0].size(), 1);
        clear_q(0);
        drive_line(0, {1'b1, 8'h3C, 1'b0}, 10);
        idle(2);
        check_one("post_brk", 0, 9'h03C, 3'b000);

        // 8N2 back-to-back, zero idle gap
        clear_q(2);
        drive_line(2, {2'b11, 8'h00, 1'b0}, 11);
        drive_line(2, {2'b11, 8'hFF, 1'b0}, 11);
        drive_line(2, {2'b11, 8'h81, 1'b0}, 11);
        idle(2);
        check_value("b2b_count", vq[2].size(), 3);
        if (vq[2].size() == 3) begin
            check_value("b2b_gap1", vq[2][1] - vq[2][0], 176);
            check_value("b2b_gap2", vq[2][2] - vq[2][1], 176);
            check_value("b2b_d0", dq[2][0], 9'h000);
            check_value("b2b_d1", dq[2][1], 9'h0FF);
            check_value("b2b_d2", dq[2][2], 9'h081);
            check_value("b2b_flags", {fq[2][0], fq[2][1], fq[2][2]}, 9'h000);
            check_value("b2b_latency", vq[2][2] - (brise[2] - 1), 169);
        end

        // Reset during data bit 3 of 0xC3; sender abandons the frame
        clear_q(0);
        drive_line(0, {8'hC3, 1'b0}, 4);
        rx0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        rx0    = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check_value("rst_mid_data", d0, 8'h00);
        check_value("rst_mid_ctrl", {busy[0], dv[0], perr[0], ferr[0], brk[0]}, 5'b00000);
        idle(12);
        check_value("rst_mid_count", vq[0].size(), 0);
        drive_line(0, {1'b1, 8'h3C, 1'b0}, 10);
        idle(2);
        check_one("post_rst", 0, 9'h03C, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
